dbus_responder: RTL and testbench

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/dbus_responder.sv | 120 ++++++++++++
 tb/tb_dbus_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - data-bus responder: RAM, GPIO and match timer
module dbus_responder #(
    parameter int DATA_SIZE = 1024,
    parameter int ADDR_W    = $clog2(DATA_SIZE - 1),
    parameter int DATA_W    = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] ddata_w,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] ddata_r,
    output logic [DATA_W-1:0] gpio_out,
    output logic              irq
);

    localparam int RAM_WORDS = DATA_SIZE / 2;

    localparam logic [ADDR_W-2:0] OFF_GPIO   = (ADDR_W-1)'(0);
    localparam logic [ADDR_W-2:0] OFF_TCNT   = (ADDR_W-1)'(1);
    localparam logic [ADDR_W-2:0] OFF_TCMP   = (ADDR_W-1)'(2);
    localparam logic [ADDR_W-2:0] OFF_STATUS = (ADDR_W-1)'(3);

    logic [DATA_W-1:0] ram [RAM_WORDS];

    logic [DATA_W-1:0] tcnt;
    logic [DATA_W-1:0] tcmp;
    logic              ten;
    logic              match;

    logic              sel_mmio;
    logic [ADDR_W-2:0] offset;
    logic              wr_gpio;
    logic              wr_tcnt;
    logic              wr_tcmp;
    logic              wr_status;
    logic              match_set;
    logic [DATA_W-1:0] mmio_rdata;
    logic [DATA_W-1:0] rdata;

    assign sel_mmio = daddr[ADDR_W-1];
    assign offset   = daddr[ADDR_W-2:0];
    assign irq      = match;

    // Register write strobes and the timer compare hit, all from current state
    always_comb begin
        wr_gpio   = MemWrite && sel_mmio && (offset == OFF_GPIO);
        wr_tcnt   = MemWrite && sel_mmio && (offset == OFF_TCNT);
        wr_tcmp   = MemWrite && sel_mmio && (offset == OFF_TCMP);
        wr_status = MemWrite && sel_mmio && (offset == OFF_STATUS);
        match_set = ten && (tcnt == tcmp);
    end

    // Read mux sees pre-edge values, so a same-cycle write returns the old data
    always_comb begin
        mmio_rdata = '0;
        case (offset)
            OFF_GPIO:   mmio_rdata = gpio_out;
            OFF_TCNT:   mmio_rdata = tcnt;
            OFF_TCMP:   mmio_rdata = tcmp;
            OFF_STATUS: mmio_rdata = {{(DATA_W-2){1'b0}}, ten, match};
            default:    mmio_rdata = '0;
        endcase
        rdata = sel_mmio ? mmio_rdata : ram[offset];
    end

    // RAM has no reset; writes are blocked while reset is held
    always_ff @(posedge CLK) begin
        if (RESET_N && MemWrite && !sel_mmio) begin
            ram[offset] <= ddata_w;
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ddata_r <= '0;
        end else if (MemRead) begin
            ddata_r <= rdata;
        end
    end

    // GPIO output register
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            gpio_out <= '0;
        end else if (wr_gpio) begin
            gpio_out <= ddata_w;
        end
    end

    // Timer: software writes beat the increment; a match set beats the W1C clear
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            tcnt  <= '0;
            tcmp  <= '1;
            ten   <= 1'b0;
            match <= 1'b0;
        end else begin
            if (wr_tcnt) begin
                tcnt <= ddata_w;
            end else if (ten) begin
                tcnt <= tcnt + DATA_W'(1);
            end
            if (wr_tcmp) begin
                tcmp <= ddata_w;
            end
            if (wr_status) begin
                ten <= ddata_w[1];
            end
            if (match_set) begin
                match <= 1'b1;
            end else if (wr_status && ddata_w[0]) begin
                match <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
// tb/tb_dbus_responder.sv - randomized model-checked bench for dbus_responder
module tb_dbus_responder;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [9:0]  daddr = '0;
    logic [31:0] ddata_w = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ddata_r;
    logic [31:0] gpio_out;
    logic        irq;

    dbus_responder dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .daddr    (daddr),
        .ddata_w  (ddata_w),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ddata_r  (ddata_r),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_ram [512];
    bit          m_ram_v [512];
    logic [31:0] m_rd = '0;
    bit          m_rd_known = 1'b1;
    logic [31:0] m_gpio = '0;
    logic [31:0] m_tcnt = '0;
    logic [31:0] m_tcmp = '1;
    bit          m_ten = 1'b0;
    bit          m_match = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [9:0] a);
        case (a)
            10'h200: return m_gpio;
            10'h201: return m_tcnt;
            10'h202: return m_tcmp;
            10'h203: return {30'b0, m_ten, m_match};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the register map, from the inputs held across that edge
    task automatic model_step();
        bit          hit;
        bit          clr;
        logic [31:0] nxt_cnt;
        if (!RESET_N) begin
            m_rd = 32'h0; m_rd_known = 1'b1;
            m_gpio = 32'h0; m_tcnt = 32'h0; m_tcmp = 32'hFFFF_FFFF;
            m_ten = 1'b0; m_match = 1'b0;
            return;
        end
        if (MemRead) begin
            if (!daddr[9]) begin
                m_rd_known = m_ram_v[daddr[8:0]];
                m_rd = m_ram[daddr[8:0]];
            end else begin
                m_rd_known = 1'b1;
                m_rd = model_read(daddr);
            end
        end
        hit = m_ten && (m_tcnt == m_tcmp);
        nxt_cnt = m_ten ? m_tcnt + 32'd1 : m_tcnt;
        clr = 1'b0;
        if (MemWrite) begin
            if (!daddr[9]) begin
                m_ram[daddr[8:0]] = ddata_w;
                m_ram_v[daddr[8:0]] = 1'b1;
            end else begin
                case (daddr)
                    10'h200: m_gpio = ddata_w;
                    10'h201: nxt_cnt = ddata_w;
                    10'h202: m_tcmp = ddata_w;
                    10'h203: begin m_ten = ddata_w[1]; clr = ddata_w[0]; end
                    default: ;
                endcase
            end
        end
        m_tcnt = nxt_cnt;
        if (hit) m_match = 1'b1;
        else if (clr) m_match = 1'b0;
    endtask

    task automatic cyc(input bit rd, input bit wr, input logic [9:0] a,
                       input logic [31:0] d, input bit rst_n);
        MemRead = rd; MemWrite = wr; daddr = a; ddata_w = d; RESET_N = rst_n;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    // Every cycle, DUT outputs against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            if (m_rd_known) chk("model_ddata_r", ddata_r, m_rd);
            chk("model_gpio_out", gpio_out, m_gpio);
            chk("model_irq", {31'b0, irq}, {31'b0, m_match});
        end
    end

    initial begin
        logic [9:0]  a;
        logic [31:0] d;
        int          k;
        for (int i = 0; i < 512; i++) m_ram_v[i] = 1'b0;

        cyc(0, 0, 10'h0, 32'h0, 0);
        cyc(1, 1, 10'h200, 32'hFFFF_FFFF, 0);
        chk_en = 1'b1;
        chk("rst_ddata_r", ddata_r, 32'h0);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        cyc(1, 0, 10'h202, 32'h0, 1);
        chk("rst_tcmp", ddata_r, 32'hFFFF_FFFF);
        cyc(1, 0, 10'h203, 32'h0, 1);
        chk("rst_status", ddata_r, 32'h0);

        // RAM round trip and hold
        cyc(0, 1, 10'h005, 32'hDEAD_BEEF, 1);
        cyc(1, 0, 10'h005, 32'h0, 1);
        chk("ram_rt", ddata_r, 32'hDEAD_BEEF);
        cyc(0, 0, 10'h006, 32'h0, 1);
        chk("ram_hold", ddata_r, 32'hDEAD_BEEF);

        // Read-before-write
        cyc(0, 1, 10'h010, 32'h1111_1111, 1);
        cyc(1, 1, 10'h010, 32'h2222_2222, 1);
        chk("rbw_old", ddata_r, 32'h1111_1111);
        cyc(1, 0, 10'h010, 32'h0, 1);
        chk("rbw_new", ddata_r, 32'h2222_2222);

        // Timer wrap and match
        cyc(0, 1, 10'h201, 32'hFFFF_FFFE, 1);
        cyc(0, 1, 10'h202, 32'h0000_0001, 1);
        cyc(0, 1, 10'h203, 32'h0000_0002, 1);
        cyc(0, 0, 10'h0, 32'h0, 1);
        cyc(1, 0, 10'h201, 32'h0, 1);
        chk("tmr_ffffffff", ddata_r, 32'hFFFF_FFFF);
        cyc(1, 0, 10'h201, 32'h0, 1);
        chk("tmr_wrap0", ddata_r, 32'h0);
        chk("tmr_irq_low", {31'b0, irq}, 32'h0);
        cyc(1, 0, 10'h201, 32'h0, 1);
        chk("tmr_one", ddata_r, 32'h1);
        chk("tmr_irq_high", {31'b0, irq}, 32'h1);

        // W1C clears, then loses against a same-cycle set
        cyc(0, 1, 10'h203, 32'h0000_0003, 1);
        chk("w1c_clear", {31'b0, irq}, 32'h0);
        cyc(0, 1, 10'h202, 32'h0000_0050, 1);
        cyc(0, 1, 10'h201, 32'h0000_004E, 1);
        cyc(0, 0, 10'h0, 32'h0, 1);
        cyc(0, 0, 10'h0, 32'h0, 1);
        chk("pre_set_irq", {31'b0, irq}, 32'h0);
        cyc(0, 1, 10'h203, 32'h0000_0003, 1);
        chk("set_beats_w1c", {31'b0, irq}, 32'h1);

        // Reset mid-operation with a colliding write
        cyc(0, 1, 10'h200, 32'hA5A5_A5A5, 1);
        chk("gpio_wr", gpio_out, 32'hA5A5_A5A5);
        cyc(1, 1, 10'h200, 32'h1234_0000, 0);
        chk("mid_rst_gpio", gpio_out, 32'h0);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        chk("mid_rst_rd", ddata_r, 32'h0);
        cyc(0, 0, 10'h0, 32'h0, 1);
        cyc(1, 0, 10'h201, 32'h0, 1);
        chk("mid_rst_tcnt", ddata_r, 32'h0);
        cyc(1, 0, 10'h202, 32'h0, 1);
        chk("mid_rst_tcmp", ddata_r, 32'hFFFF_FFFF);

        // Unmapped MMIO
        cyc(0, 1, 10'h200, 32'h5A5A_5A5A, 1);
        cyc(0, 1, 10'h3FF, 32'h1234_5678, 1);
        cyc(1, 0, 10'h3FF, 32'h0, 1);
        chk("unmapped_rd", ddata_r, 32'h0);
        chk("unmapped_gpio", gpio_out, 32'h5A5A_5A5A);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 9);
            if (k < 5) a = (($urandom_range(0, 15) == 0) ? 10'h1FF : 10'($urandom_range(0, 15)));
            else if (k < 9) a = 10'h200 + 10'($urandom_range(0, 3));
            else a = (($urandom_range(0, 1) == 0) ? 10'h3FF : 10'h204 + 10'($urandom_range(0, 20)));
            case (a)
                10'h201: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 64));
                10'h202: d = m_tcnt + 32'($urandom_range(0, 6));
                10'h203: d = 32'($urandom_range(0, 3));
                default: d = $urandom;
            endcase
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), a, d,
                ($urandom_range(0, 149) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
